// File: rtl/dffen_mon.sv
// -----------------------------------------------------------------------------
// dffen_mon
//
// Watches a bank of flop-enable signals and flags two kinds of misbehaviour:
//   * unknown enable : en[i] is X or Z in a sampled cycle
//   * stuck enable   : en[i] has been high for more than MAX_RUN cycles in a row
// The first error is latched (lowest channel wins, unknown beats stuck on the
// same channel) and held until acknowledged. Errors that arrive while one is
// already latched set the sticky miss flag. Each channel also keeps a
// saturating count of its enable-high cycles.
//
// Parameters
//   N        number of monitored channels (1..32)
//   MAX_RUN  longest allowed run of consecutive high cycles; 0 = no stuck check
//   CNT_W    width of each activity counter (>= 4)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   en        in   [N]           monitored flop-enables
//   clr       in   clears activity counters and miss
//   err_ack   in   acknowledges the latched error (ignored when none latched)
//   err       out  high while an error is latched
//   err_ch    out  [CH_W]        channel of the latched error
//   err_code  out  [2]           01 unknown enable, 10 stuck enable
//   miss      out  sticky: error seen while another was latched
//   act_cnt   out  [N*CNT_W]     activity count of channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module dffen_mon #(
   parameter int N       = 4,
   parameter int MAX_RUN = 16,
   parameter int CNT_W   = 16,
   localparam int CH_W   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       en,
   input  logic               clr,
   input  logic               err_ack,
   output logic               err,
   output logic [CH_W-1:0]    err_ch,
   output logic [1:0]         err_code,
   output logic               miss,
   output logic [N*CNT_W-1:0] act_cnt
);

   localparam int  RUN_W    = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;
   localparam bit  STUCK_ON = (MAX_RUN != 0);

   typedef enum logic [1:0] {
      CODE_NONE    = 2'b00,
      CODE_UNKNOWN = 2'b01,
      CODE_STUCK   = 2'b10
   } err_code_e;

   typedef enum logic {
      ARMED,
      LATCHED
   } state_e;

   // Per-channel classification of the current en sample.
   logic [N-1:0] en_one;   // en[i] is a clean 1
   logic [N-1:0] unk;      // en[i] is X or Z
   logic [N-1:0] stuck;    // en[i] just completed its (MAX_RUN+1)th high cycle

   // ---------------------------------------------------------------------------
   // Per-channel run tracking and activity counting
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [RUN_W-1:0] run_q;      // consecutive high cycles seen so far
      logic             reported_q; // stuck already reported for this run
      logic [CNT_W-1:0] cnt_q;

      // Four-state compare: a 2-state netlist sees these as constant, a 4-state
      // simulator flags X/Z on the enable.
      assign en_one[i] = (en[i] === 1'b1);
      assign unk[i]    = (en[i] !== 1'b0) && (en[i] !== 1'b1);

      // The run counter saturates at MAX_RUN, so reported_q is what keeps a
      // channel held high from re-reporting every cycle.
      assign stuck[i]  = STUCK_ON && en_one[i] && !reported_q &&
                         (run_q == RUN_W'(MAX_RUN));

      // NOTE: sequential state is assigned with non-blocking (<=) so every flop
      // samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            run_q      <= '0;
            reported_q <= 1'b0;
         end else if (en_one[i]) begin
            if (run_q != RUN_W'(MAX_RUN))
               run_q <= run_q + 1'b1;
            if (stuck[i])
               reported_q <= 1'b1;
         end else begin
            // A low or unknown enable breaks the run and re-arms the stuck check.
            run_q      <= '0;
            reported_q <= 1'b0;
         end
      end

      // NOTE: these counters are a handful of flops per channel, not a RAM, so
      // they take the reset directly; a real memory array would not.
      always_ff @(posedge clk) begin
         if (!rst_n)
            cnt_q <= '0;
         else if (clr)
            cnt_q <= '0;                 // clear wins over a same-cycle increment
         else if (en_one[i] && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
      end

      assign act_cnt[i*CNT_W +: CNT_W] = cnt_q;
   end

   // ---------------------------------------------------------------------------
   // Error selection: lowest channel index wins, unknown beats stuck
   // ---------------------------------------------------------------------------
   logic            sel_hit;
   logic [CH_W-1:0] sel_ch;
   err_code_e       sel_code;

   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no path leaves it unassigned and a latch is never inferred.
   always_comb begin
      sel_hit  = 1'b0;
      sel_ch   = '0;
      sel_code = CODE_NONE;
      // Scan downwards so the lowest erroring channel is the last writer.
      for (int i = N - 1; i >= 0; i--) begin
         if (unk[i] || stuck[i]) begin
            sel_hit  = 1'b1;
            sel_ch   = CH_W'(i);
            sel_code = unk[i] ? CODE_UNKNOWN : CODE_STUCK;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Latch FSM with registered outputs
   // ---------------------------------------------------------------------------
   state_e    state_q;
   err_code_e code_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ARMED;
         err     <= 1'b0;
         err_ch  <= '0;
         code_q  <= CODE_NONE;
         miss    <= 1'b0;
      end else begin
         case (state_q)
            ARMED: begin
               // err_ack has no meaning here and is ignored.
               if (sel_hit) begin
                  state_q <= LATCHED;
                  err     <= 1'b1;
                  err_ch  <= sel_ch;
                  code_q  <= sel_code;
               end
            end
            LATCHED: begin
               // A new error is never latched while one is held, even in the
               // acknowledge cycle; it only raises miss.
               if (sel_hit)
                  miss <= 1'b1;
               if (err_ack) begin
                  state_q <= ARMED;
                  err     <= 1'b0;
               end
            end
            default: begin
               state_q <= ARMED;
               err     <= 1'b0;
            end
         endcase

         // clr zeroes miss even if an error would set it this cycle.
         if (clr)
            miss <= 1'b0;
      end
   end

   assign err_code = code_q;

endmodule
